// File: rtl/mac_pkg.sv
// Shared constants and helpers for the multiply-accumulate pipeline.
package mac_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ACC_W  = 32;
    localparam int unsigned DEF_OUT_W  = 16;
    localparam int unsigned DEF_SHIFT  = 0;
    localparam int unsigned DEF_SIGNED = 1;

    // Helpers compute at this width; callers truncate, so ACC_W + 1 must not exceed it.
    localparam int unsigned MAX_W = 64;

    // Half-LSB offset added before a right shift by 'shift' (round half up).
    function automatic logic [MAX_W-1:0] round_offset(input int unsigned shift);
        logic [MAX_W-1:0] off;
        off = '0;
        if (shift != 0) begin
            off = MAX_W'(1) << (shift - 1);
        end
        return off;
    endfunction

    // Upper clamp bound for an out_w-bit result.
    function automatic logic [MAX_W-1:0] sat_hi(input int unsigned out_w, input int unsigned is_signed);
        logic [MAX_W-1:0] one;
        one = MAX_W'(1);
        if (is_signed != 0) begin
            return (one << (out_w - 1)) - one;
        end
        return (one << out_w) - one;
    endfunction

    // Lower clamp bound for an out_w-bit result (two's complement at MAX_W bits).
    function automatic logic [MAX_W-1:0] sat_lo(input int unsigned out_w, input int unsigned is_signed);
        logic [MAX_W-1:0] one;
        one = MAX_W'(1);
        if (is_signed != 0) begin
            return ~((one << (out_w - 1)) - one);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mac_pipe_if.sv
// Operand stream in, quantised frame result out.
interface mac_pipe_if
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OUT_W  = DEF_OUT_W
);
    logic              in_valid;
    logic              in_first;
    logic              in_last;
    logic [DATA_W-1:0] d_in_a;
    logic [DATA_W-1:0] d_in_b;
    logic              out_valid;
    logic [OUT_W-1:0]  d_out;
    logic              sat;

    // Fetch side: drives operands, consumes results.
    modport master (
        output in_valid, in_first, in_last, d_in_a, d_in_b,
        input  out_valid, d_out, sat
    );

    // MAC side.
    modport slave (
        input  in_valid, in_first, in_last, d_in_a, d_in_b,
        output out_valid, d_out, sat
    );
endinterface

// File: rtl/mac_quant.sv
// Combinational round, shift and saturate from the accumulator to the output width.
module mac_quant
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned SHIFT  = DEF_SHIFT,
    parameter int unsigned SIGNED = DEF_SIGNED
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] q,
    output logic             sat
);
    // One guard bit keeps the rounding add from overflowing in either signedness.
    localparam int unsigned XW = ACC_W + 1;
    localparam logic [XW-1:0] OFFSET = XW'(round_offset(SHIFT));
    localparam logic [XW-1:0] HI     = XW'(sat_hi(OUT_W, SIGNED));
    localparam logic [XW-1:0] LO     = XW'(sat_lo(OUT_W, SIGNED));

    logic [XW-1:0] ext;
    logic [XW-1:0] rnd;
    logic [XW-1:0] shf;

    // Extend, round, shift, then clamp to the representable output range.
    always_comb begin
        if (SIGNED != 0) begin
            ext = XW'($signed(acc));
        end else begin
            ext = XW'(acc);
        end
        rnd = ext + OFFSET;
        if (SIGNED != 0) begin
            shf = XW'($signed(rnd) >>> SHIFT);
        end else begin
            shf = rnd >> SHIFT;
        end
        q   = shf[OUT_W-1:0];
        sat = 1'b0;
        if (SIGNED != 0) begin
            if ($signed(shf) > $signed(HI)) begin
                q   = HI[OUT_W-1:0];
                sat = 1'b1;
            end else if ($signed(shf) < $signed(LO)) begin
                q   = LO[OUT_W-1:0];
                sat = 1'b1;
            end
        end else if (shf > HI) begin
            q   = HI[OUT_W-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/mac_pipe.sv
// Three-stage pipelined multiply-accumulate: product, accumulate, quantised output.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned SHIFT  = DEF_SHIFT,
    parameter int unsigned SIGNED = DEF_SIGNED
) (
    input logic       clk,
    input logic       rst,
    mac_pipe_if.slave bus
);
    localparam int unsigned PW = 2 * DATA_W;

    logic [PW-1:0]    a_x;
    logic [PW-1:0]    b_x;
    logic [PW-1:0]    mult;
    logic             p_valid;
    logic             p_first;
    logic             p_last;
    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] prod_x;
    logic [ACC_W-1:0] acc;
    logic             a_fire;
    logic [OUT_W-1:0] q;
    logic             q_sat;

    // Extend operands to full product width so the low 2*DATA_W bits are exact.
    always_comb begin
        if (SIGNED != 0) begin
            a_x = PW'($signed(bus.d_in_a));
            b_x = PW'($signed(bus.d_in_b));
        end else begin
            a_x = PW'(bus.d_in_a);
            b_x = PW'(bus.d_in_b);
        end
        mult = a_x * b_x;
    end

    // Stage P: register the product and the beat flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            prod    <= '0;
        end else begin
            p_valid <= bus.in_valid;
            p_first <= bus.in_valid & bus.in_first;
            p_last  <= bus.in_valid & bus.in_last;
            if (bus.in_valid) begin
                prod <= mult;
            end
        end
    end

    // Widen the registered product to accumulator width.
    always_comb begin
        if (SIGNED != 0) begin
            prod_x = ACC_W'($signed(prod));
        end else begin
            prod_x = ACC_W'(prod);
        end
    end

    // Stage A: restart on first, otherwise accumulate; hold across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            a_fire <= 1'b0;
        end else begin
            a_fire <= p_valid & p_last;
            if (p_valid) begin
                acc <= p_first ? prod_x : acc + prod_x;
            end
        end
    end

    mac_quant #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .SIGNED (SIGNED)
    ) u_quant (
        .acc (acc),
        .q   (q),
        .sat (q_sat)
    );

    // Stage O: capture the quantised result at frame end; result holds between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.d_out     <= '0;
            bus.sat       <= 1'b0;
        end else begin
            bus.out_valid <= a_fire;
            if (a_fire) begin
                bus.d_out <= q;
                bus.sat   <= q_sat;
            end
        end
    end
endmodule
